// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the HI/LO divide controller.
// FSM state encoding, datapath width and the nominal divider latency
// (the latency is informational only; the controller waits for div_done).
package mdu_pkg;

  localparam int DW = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam int DIV_NOMINAL_LAT = 34;

endpackage

// File: rtl/hilo_reg.sv
// hilo_reg: architectural HI/LO register pair.
// A completing divide owns both registers on its write edge. It is the younger
// instruction, so it overrides any MTHI/MTLO write from WB on that same edge.
module hilo_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          div_we,
  input  logic [DW-1:0] div_hi,
  input  logic [DW-1:0] div_lo,
  input  logic          wb_hi_we,
  input  logic          wb_lo_we,
  input  logic [DW-1:0] wb_wdata,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  logic [DW-1:0] hi_r;
  logic [DW-1:0] lo_r;
  logic [DW-1:0] hi_next_s;
  logic [DW-1:0] lo_next_s;

  // Write-priority mux: divide result first, then WB moves, else hold
  always_comb begin
    hi_next_s = hi_r;
    lo_next_s = lo_r;
    if (div_we) begin
      hi_next_s = div_hi;
      lo_next_s = div_lo;
    end else begin
      if (wb_hi_we) begin
        hi_next_s = wb_wdata;
      end else begin
        hi_next_s = hi_r;
      end
      if (wb_lo_we) begin
        lo_next_s = wb_wdata;
      end else begin
        lo_next_s = lo_r;
      end
    end
  end

  // HI/LO storage, cleared by asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r <= {DW{1'b0}};
      lo_r <= {DW{1'b0}};
    end else begin
      hi_r <= hi_next_s;
      lo_r <= lo_next_s;
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: EX-stage controller for the iterative divider and owner of HI/LO.
// Latches DIV/DIVU operands, holds div_start high for the whole divide, stalls
// the pipeline until div_done, then writes quotient->LO and remainder->HI.
// A WB state always follows a divide so div_start is low for at least one cycle,
// which clears the divider's iteration counter before the next operation.
// Optional build macro: DIV_ZERO_BYPASS_EN -- a divisor of zero skips the
// divider entirely (IDLE -> WB) and leaves HI/LO untouched.
module hilo_div_ctrl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_div_valid,
  input  logic          ex_div_sign,
  input  logic [DW-1:0] ex_rs,
  input  logic [DW-1:0] ex_rt,
  input  logic          flush,
  input  logic          wb_hi_we,
  input  logic          wb_lo_we,
  input  logic [DW-1:0] wb_wdata,
  output logic          div_start,
  output logic          div_sign,
  output logic [DW-1:0] div_a,
  output logic [DW-1:0] div_b,
  input  logic [DW-1:0] div_quotient,
  input  logic [DW-1:0] div_remainder,
  input  logic          div_done,
  output logic          stall_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  import mdu_pkg::*;

  logic [1:0]    state_r;
  logic [1:0]    next_state_s;
  logic [DW-1:0] opa_r;
  logic [DW-1:0] opb_r;
  logic          sign_r;
  logic          start_r;
  logic          issue_s;
  logic          load_ops_s;
  logic          div_we_s;
  logic          stall_s;
  logic          start_next_s;

  assign issue_s = ex_div_valid && !flush;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state: flush beats div_done in BUSY; WB always returns to IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (issue_s) begin
`ifdef DIV_ZERO_BYPASS_EN
          if (ex_rt == {DW{1'b0}}) begin
            next_state_s = S_WB;
          end else begin
            next_state_s = S_BUSY;
          end
`else
          next_state_s = S_BUSY;
`endif
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (flush) begin
          next_state_s = S_IDLE;
        end else if (div_done) begin
          next_state_s = S_WB;
        end else begin
          next_state_s = S_BUSY;
        end
      end
      S_WB: begin
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // FSM outputs: stall, operand load, HI/LO write strobe, next div_start
  always_comb begin
    stall_s      = 1'b0;
    load_ops_s   = 1'b0;
    div_we_s     = 1'b0;
    start_next_s = (next_state_s == S_BUSY);
    case (state_r)
      S_IDLE: begin
        stall_s    = issue_s;
        load_ops_s = (next_state_s == S_BUSY);
      end
      S_BUSY: begin
        stall_s  = 1'b1;
        div_we_s = div_done && !flush;
      end
      S_WB: begin
        stall_s  = 1'b0;
        div_we_s = 1'b0;
      end
      default: begin
        stall_s  = 1'b0;
        div_we_s = 1'b0;
      end
    endcase
  end

  // Operand latch: captured on issue and held steady for the whole divide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opa_r  <= {DW{1'b0}};
      opb_r  <= {DW{1'b0}};
      sign_r <= 1'b0;
    end else if (load_ops_s) begin
      opa_r  <= ex_rs;
      opb_r  <= ex_rt;
      sign_r <= ex_div_sign;
    end else begin
      opa_r  <= opa_r;
      opb_r  <= opb_r;
      sign_r <= sign_r;
    end
  end

  // Registered divider start, high exactly while the FSM is in BUSY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_r <= 1'b0;
    end else begin
      start_r <= start_next_s;
    end
  end

  hilo_reg #(
    .DW (DW)
  ) u_hilo_reg (
    .clk      (clk),
    .rst      (rst),
    .div_we   (div_we_s),
    .div_hi   (div_remainder),
    .div_lo   (div_quotient),
    .wb_hi_we (wb_hi_we),
    .wb_lo_we (wb_lo_we),
    .wb_wdata (wb_wdata),
    .hi       (hi_o),
    .lo       (lo_o)
  );

  assign div_start = start_r;
  assign div_sign  = sign_r;
  assign div_a     = opa_r;
  assign div_b     = opb_r;
  assign stall_o   = stall_s;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: self-checking bench for hilo_div_ctrl with a behavioural
// divider (done in the 34th start-high cycle, outputs garbage outside done).
module tb_hilo_div_ctrl;

  localparam int DW  = 32;
  localparam int LAT = 34;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ex_div_valid = 1'b0;
  logic          ex_div_sign = 1'b0;
  logic [DW-1:0] ex_rs = '0;
  logic [DW-1:0] ex_rt = '0;
  logic          flush = 1'b0;
  logic          wb_hi_we = 1'b0;
  logic          wb_lo_we = 1'b0;
  logic [DW-1:0] wb_wdata = '0;
  logic          div_start;
  logic          div_sign;
  logic [DW-1:0] div_a;
  logic [DW-1:0] div_b;
  logic [DW-1:0] div_quotient;
  logic [DW-1:0] div_remainder;
  logic          div_done;
  logic          stall_o;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DW-1:0] exp_hi = '0;
  logic [DW-1:0] exp_lo = '0;

  hilo_div_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .ex_div_valid(ex_div_valid), .ex_div_sign(ex_div_sign),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we),
    .wb_wdata(wb_wdata), .div_start(div_start), .div_sign(div_sign), .div_a(div_a),
    .div_b(div_b), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_done(div_done), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Reference divide: MIPS truncating semantics; by-zero gives q=all ones, r=dividend
  function automatic logic [2*DW-1:0] ref_div(input logic s, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    if (b == '0) begin q = '1; r = a; end
    else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    else begin q = a / b; r = a % b; end
    return {r, q};
  endfunction

  // Behavioural divider: counts start-high cycles, done pulses in the 34th
  int unsigned busy_cnt;
  logic spur_done = 1'b0;
  logic model_done;
  logic [DW-1:0] mq, mr;
  always @(posedge clk or negedge rst) begin
    if (!rst) busy_cnt <= 0;
    else if (!div_start) busy_cnt <= 0;
    else busy_cnt <= busy_cnt + 1;
  end
  assign model_done    = div_start && (busy_cnt == LAT - 1);
  assign div_done      = model_done | spur_done;
  assign {mr, mq}      = ref_div(div_sign, div_a, div_b);
  assign div_quotient  = div_done ? mq : ~mq;
  assign div_remainder = div_done ? mr : ~mr;

  // Issue one divide and follow it to the first non-stalled cycle (WB)
  task automatic run_div(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic lo_at_done, input logic [DW-1:0] lo_data,
                         output int st_n, output int sn_n);
    st_n = 0; sn_n = 0;
    @(negedge clk);
    ex_div_valid = 1'b1; ex_div_sign = s; ex_rs = a; ex_rt = b;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (stall_o) st_n++;
      if (div_start) sn_n++;
      if (div_done && div_start) begin
        total_cnt++;
        if ({div_sign, div_a, div_b} !== {s, a, b})
          $display("FAIL operands: got %b/%h/%h exp %b/%h/%h", div_sign, div_a, div_b, s, a, b);
        else pass_cnt++;
        if (lo_at_done) begin wb_lo_we = 1'b1; wb_wdata = lo_data; end
      end
      if (i > 0 && !stall_o) break;
      @(negedge clk);
      ex_div_valid = 1'b0; wb_lo_we = 1'b0;
    end
    total_cnt++;
    if (div_start !== 1'b0) $display("FAIL start_gap: div_start=%b exp 0 after divide", div_start);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL rst_stall: got %b exp 0", stall_o); else pass_cnt++;
    total_cnt++; if (div_start !== 1'b0) $display("FAIL rst_start: got %b exp 0", div_start); else pass_cnt++;
    total_cnt++; if ({div_sign, div_a, div_b} !== '0) $display("FAIL rst_ops: got %b/%h/%h exp 0", div_sign, div_a, div_b); else pass_cnt++;
    total_cnt++; if ({hi_o, lo_o} !== '0) $display("FAIL rst_hilo: got %h/%h exp 0/0", hi_o, lo_o); else pass_cnt++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_div_signed();
    int st, sn;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, '0, st, sn);
    exp_lo = 32'hFFFF_FFFD; exp_hi = 32'hFFFF_FFFF;
    total_cnt++; if (lo_o !== exp_lo) $display("FAIL sdiv_lo: got %h exp %h", lo_o, exp_lo); else pass_cnt++;
    total_cnt++; if (hi_o !== exp_hi) $display("FAIL sdiv_hi: got %h exp %h", hi_o, exp_hi); else pass_cnt++;
    total_cnt++; if (st !== 35) $display("FAIL sdiv_stall_len: got %0d exp 35", st); else pass_cnt++;
    total_cnt++; if (sn !== 34) $display("FAIL sdiv_start_len: got %0d exp 34", sn); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int st, sn;
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0, '0, st, sn);
    exp_lo = 32'h0FFF_FFFF; exp_hi = 32'h0000_000F;
    total_cnt++; if ({hi_o, lo_o} !== {exp_hi, exp_lo}) $display("FAIL divu1: got %h/%h exp %h/%h", hi_o, lo_o, exp_hi, exp_lo); else pass_cnt++;
    run_div(1'b0, 32'd100, 32'd7, 1'b0, '0, st, sn);
    exp_lo = 32'd14; exp_hi = 32'd2;
    total_cnt++; if ({hi_o, lo_o} !== {exp_hi, exp_lo}) $display("FAIL divu2: got %h/%h exp %h/%h", hi_o, lo_o, exp_hi, exp_lo); else pass_cnt++;
    total_cnt++; if (st !== 35) $display("FAIL b2b_stall_len: got %0d exp 35", st); else pass_cnt++;
  endtask

  task automatic test_flush();
    int st, sn;
    bit seen;
    @(negedge clk); wb_hi_we = 1'b1; wb_wdata = 32'hAAAA;
    @(negedge clk); wb_hi_we = 1'b0; wb_lo_we = 1'b1; wb_wdata = 32'h5555;
    @(negedge clk); wb_lo_we = 1'b0;
    exp_hi = 32'hAAAA; exp_lo = 32'h5555;
    // flush in BUSY cycle 10
    ex_div_valid = 1'b1; ex_div_sign = 1'b1; ex_rs = 32'd1000; ex_rt = 32'd3;
    @(negedge clk); ex_div_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    total_cnt++; if ({stall_o, div_start} !== 2'b00) $display("FAIL flush_busy: stall/start got %b%b exp 00", stall_o, div_start); else pass_cnt++;
    total_cnt++; if ({hi_o, lo_o} !== {exp_hi, exp_lo}) $display("FAIL flush_hilo: got %h/%h exp %h/%h", hi_o, lo_o, exp_hi, exp_lo); else pass_cnt++;
    // flush in the same cycle as div_done
    @(negedge clk);
    ex_div_valid = 1'b1; ex_div_sign = 1'b0; ex_rs = 32'd50; ex_rt = 32'd5;
    @(negedge clk); ex_div_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (div_done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total_cnt++; if (!seen) $display("FAIL flush_done_wait: div_done got 0 exp 1 within budget"); else pass_cnt++;
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    total_cnt++; if ({hi_o, lo_o} !== {exp_hi, exp_lo}) $display("FAIL flush_wins: got %h/%h exp %h/%h", hi_o, lo_o, exp_hi, exp_lo); else pass_cnt++;
    total_cnt++; if ({stall_o, div_start} !== 2'b00) $display("FAIL flush_done_state: stall/start got %b%b exp 00", stall_o, div_start); else pass_cnt++;
    // new divide after flush
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, '0, st, sn);
    exp_lo = 32'hFFFF_FFF2; exp_hi = 32'hFFFF_FFFE;
    total_cnt++; if ({hi_o, lo_o} !== {exp_hi, exp_lo}) $display("FAIL post_flush_div: got %h/%h exp %h/%h", hi_o, lo_o, exp_hi, exp_lo); else pass_cnt++;
    total_cnt++; if (st !== 35) $display("FAIL post_flush_stall: got %0d exp 35", st); else pass_cnt++;
    // flush in IDLE together with a valid divide
    @(negedge clk); ex_div_valid = 1'b1; flush = 1'b1;
    #1;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL idle_flush_stall: got %b exp 0", stall_o); else pass_cnt++;
    @(negedge clk); ex_div_valid = 1'b0; flush = 1'b0;
    #1;
    total_cnt++; if ({stall_o, div_start} !== 2'b00) $display("FAIL idle_flush_start: stall/start got %b%b exp 00", stall_o, div_start); else pass_cnt++;
  endtask

  task automatic test_priority();
    int st, sn;
    run_div(1'b0, 32'd81, 32'd9, 1'b1, 32'h1234, st, sn);
    exp_lo = 32'h9; exp_hi = 32'h0;
    total_cnt++; if ({hi_o, lo_o} !== {exp_hi, exp_lo}) $display("FAIL div_over_wb: got %h/%h exp %h/%h", hi_o, lo_o, exp_hi, exp_lo); else pass_cnt++;
    @(negedge clk); wb_hi_we = 1'b1; wb_wdata = 32'hBEEF;
    @(negedge clk); wb_hi_we = 1'b0;
    exp_hi = 32'hBEEF;
    #1;
    total_cnt++; if ({hi_o, lo_o} !== {exp_hi, exp_lo}) $display("FAIL mthi_idle: got %h/%h exp %h/%h", hi_o, lo_o, exp_hi, exp_lo); else pass_cnt++;
  endtask

  task automatic test_spurious_done();
    @(negedge clk); spur_done = 1'b1;
    #1;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL spur_stall: got %b exp 0", stall_o); else pass_cnt++;
    @(negedge clk); spur_done = 1'b0;
    #1;
    total_cnt++; if ({hi_o, lo_o} !== {exp_hi, exp_lo}) $display("FAIL spur_hilo: got %h/%h exp %h/%h", hi_o, lo_o, exp_hi, exp_lo); else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int st, sn;
    run_div(1'b1, 32'h0000_0777, 32'd0, 1'b0, '0, st, sn);
`ifdef DIV_ZERO_BYPASS_EN
    total_cnt++; if (st !== 1) $display("FAIL dz_stall: got %0d exp 1", st); else pass_cnt++;
    total_cnt++; if (sn !== 0) $display("FAIL dz_start: got %0d exp 0", sn); else pass_cnt++;
`else
    exp_lo = 32'hFFFF_FFFF; exp_hi = 32'h0000_0777;
    total_cnt++; if (st !== 35) $display("FAIL dz_stall: got %0d exp 35", st); else pass_cnt++;
    total_cnt++; if (sn !== 34) $display("FAIL dz_start: got %0d exp 34", sn); else pass_cnt++;
`endif
    total_cnt++; if ({hi_o, lo_o} !== {exp_hi, exp_lo}) $display("FAIL dz_hilo: got %h/%h exp %h/%h", hi_o, lo_o, exp_hi, exp_lo); else pass_cnt++;
  endtask

  task automatic test_random();
    int st, sn;
    logic s;
    logic [DW-1:0] a, b;
    for (int k = 0; k < 8; k++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (k < 4) ? DW'($urandom_range(1, 300)) : $urandom;
      if (b == '0) b = 32'd1;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      run_div(s, a, b, 1'b0, '0, st, sn);
      {exp_hi, exp_lo} = ref_div(s, a, b);
      total_cnt++; if ({hi_o, lo_o} !== {exp_hi, exp_lo}) $display("FAIL rand_div%0d: got %h/%h exp %h/%h", k, hi_o, lo_o, exp_hi, exp_lo); else pass_cnt++;
      total_cnt++; if (st !== 35) $display("FAIL rand_stall%0d: got %0d exp 35", k, st); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    ex_div_valid = 1'b1; ex_div_sign = 1'b1; ex_rs = 32'h0123_4567; ex_rt = 32'h55;
    @(negedge clk); ex_div_valid = 1'b0;
    // MTHI while busy still lands
    wb_hi_we = 1'b1; wb_wdata = 32'h77;
    @(negedge clk); wb_hi_we = 1'b0;
    #1;
    total_cnt++; if (hi_o !== 32'h77) $display("FAIL mthi_busy: got %h exp 00000077", hi_o); else pass_cnt++;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    total_cnt++; if ({stall_o, div_start} !== 2'b00) $display("FAIL midrst_ctl: stall/start got %b%b exp 00", stall_o, div_start); else pass_cnt++;
    total_cnt++; if ({div_sign, div_a, div_b} !== '0) $display("FAIL midrst_ops: got %b/%h/%h exp 0", div_sign, div_a, div_b); else pass_cnt++;
    total_cnt++; if ({hi_o, lo_o} !== '0) $display("FAIL midrst_hilo: got %h/%h exp 0/0", hi_o, lo_o); else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    exp_hi = '0; exp_lo = '0;
  endtask

  initial begin
    test_reset();
    test_div_signed();
    test_back_to_back();
    test_flush();
    test_priority();
    test_spurious_done();
    test_div_zero();
    test_random();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached before summary");
    $fatal(1, "time limit");
  end

endmodule
